// File: rtl/uart_pkg.sv
// Shared encodings, constants and helpers for the UART transmit path.
// Parity and baud selects match the receive chain's encodings.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic [1:0] BAUD_SEL_2400  = 2'b00;
  localparam logic [1:0] BAUD_SEL_4800  = 2'b01;
  localparam logic [1:0] BAUD_SEL_9600  = 2'b10;
  localparam logic [1:0] BAUD_SEL_19200 = 2'b11;

  localparam int BAUD_2400  = 2400;
  localparam int BAUD_4800  = 4800;
  localparam int BAUD_9600  = 9600;
  localparam int BAUD_19200 = 19200;

  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic logic parity_bit(
    input logic [7:0] data,
    input logic [1:0] ptype
  );
    logic p;
    unique case (ptype)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter: pulses bit_end on the last clock of each bit.
// The counter wraps to zero on bit_end and on restart.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DIV_W    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] baud_sel,
  input  logic       en,
  input  logic       restart,
  output logic       bit_end
);

  localparam logic [DIV_W-1:0] LIM0 = DIV_W'(CLK_FREQ / BAUD_2400 - 1);
  localparam logic [DIV_W-1:0] LIM1 = DIV_W'(CLK_FREQ / BAUD_4800 - 1);
  localparam logic [DIV_W-1:0] LIM2 = DIV_W'(CLK_FREQ / BAUD_9600 - 1);
  localparam logic [DIV_W-1:0] LIM3 = DIV_W'(CLK_FREQ / BAUD_19200 - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] lim;

  always_comb begin
    unique case (baud_sel)
      BAUD_SEL_2400:  lim = LIM0;
      BAUD_SEL_4800:  lim = LIM1;
      BAUD_SEL_9600:  lim = LIM2;
      default:        lim = LIM3;
    endcase
  end

  assign bit_end = en && (cnt_q == lim);

  always_comb begin
    cnt_d = cnt_q;
    if (restart || bit_end) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: start, 8 data bits LSB first, parity slot, stop.
// Frame settings are latched on accept and held for the whole frame.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int DIV_W    = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  output logic       data_tx,
  output logic       active_flag,
  output logic       done_flag
);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic [1:0] baud_q, baud_d;
  logic       tx_q, tx_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       accept;
  logic       bit_end;

  assign accept = (state_q == IDLE) && send;

  uart_tx_bit_timer #(
    .CLK_FREQ (CLK_FREQ),
    .DIV_W    (DIV_W)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .baud_sel (baud_q),
    .en       (state_q != IDLE),
    .restart  (accept),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_d    = par_q;
    baud_d   = baud_q;
    tx_d     = tx_q;
    active_d = active_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: if (send) begin
        state_d  = START;
        shift_d  = data_in;
        baud_d   = baud_rate;
        par_d    = parity_bit(data_in, parity_type);
        tx_d     = 1'b0;
        active_d = 1'b1;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
          state_d = PARITY;
          tx_d    = par_q;
        end else begin
          idx_d   = idx_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        state_d  = IDLE;
        active_d = 1'b0;
        done_d   = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        tx_d     = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      par_q    <= 1'b1;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign data_tx     = tx_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboard bench for uart_tx_unit at CLK_FREQ=1 MHz.
// Bit periods: 416/208/104/52 clocks for selects 00/01/10/11.
module tb_uart_tx_unit;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic [1:0] baud_rate = 2'b11;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  uart_tx_unit #(
    .CLK_FREQ (1_000_000),
    .DIV_W    (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .baud_rate   (baud_rate),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [10:0] bits;
    int          div;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;

  int checks = 0;
  int failures = 0;
  int k, bad, flag_bad;
  int frames_done = 0;
  int frames_started = 0;
  int done_seen = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int exp_done = 0;
  bit in_frame = 1'b0;

  task automatic check(input bit ok, input string name,
                       input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: times every frame bit against the queued expectation.
  always @(negedge clock) begin
    cyc++;
    if (done_flag === 1'b1) done_seen++;
    if (!reset_n) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && data_tx === 1'b0) begin
        start_cyc = cyc;
        frames_started++;
        check(exp_q.size() != 0, "unexpected_frame", 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          in_frame = 1'b1;
          k = 0;
          bad = 0;
          flag_bad = 0;
        end
      end else if (!in_frame && done_flag === 1'b1) begin
        check(done_flag !== 1'b1, "stray_done", 1, 0);
      end
      if (in_frame) begin
        if (k < 11 * cur.div) begin
          if (data_tx !== cur.bits[k / cur.div]) bad++;
          if (active_flag !== 1'b1 || done_flag !== 1'b0) flag_bad++;
          if (k % cur.div == cur.div - 1) begin
            check(bad == 0, $sformatf("bit%0d_bad_clocks", k / cur.div),
                  bad, 0);
            bad = 0;
          end
        end else begin
          check(done_flag === 1'b1 && active_flag === 1'b0 &&
                data_tx === 1'b1, "frame_end_done_active_tx",
                int'({done_flag, active_flag, data_tx}), 3'b101);
          check(flag_bad == 0, "flags_in_frame", flag_bad, 0);
          done_cyc = cyc;
          frames_done++;
          in_frame = 1'b0;
        end
        k++;
      end
    end
  end

  task automatic issue(input logic [7:0] d, input logic [1:0] p,
                       input logic [1:0] b, input logic [10:0] bits,
                       input int div);
    @(negedge clock);
    data_in = d;
    parity_type = p;
    baud_rate = b;
    send = 1'b1;
    exp_q.push_back('{bits: bits, div: div});
    @(negedge clock);
    send = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n;
    n = 0;
    while (frames_done < target && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(frames_done >= target, "frame_timeout", frames_done, target);
  endtask

  initial begin
    int d1;
    int n;
    #1 reset_n = 1'b0;
    #1;
    check(data_tx === 1'b1 && active_flag === 1'b0 && done_flag === 1'b0,
          "reset_values", int'({data_tx, active_flag, done_flag}), 3'b100);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    check(data_tx === 1'b1 && active_flag === 1'b0, "idle_line",
          int'({data_tx, active_flag}), 2'b10);
    check(done_seen == 0, "idle_no_done", done_seen, 0);

    // A5 even @52, odd @52, none(00) @208, none(11) @416, 00 even @52
    issue(8'hA5, 2'b10, 2'b11, 11'b1_0_1010_0101_0, 52);
    exp_done++;
    wait_done(exp_done, 700);
    issue(8'hA5, 2'b01, 2'b11, 11'b1_1_1010_0101_0, 52);
    exp_done++;
    wait_done(exp_done, 700);
    issue(8'hA5, 2'b00, 2'b01, 11'b1_1_1010_0101_0, 208);
    exp_done++;
    wait_done(exp_done, 2400);
    issue(8'hA5, 2'b11, 2'b00, 11'b1_1_1010_0101_0, 416);
    exp_done++;
    wait_done(exp_done, 4700);
    issue(8'h00, 2'b10, 2'b11, 11'b1_0_0000_0000_0, 52);
    exp_done++;
    wait_done(exp_done, 700);

    // send held, settings changed mid-frame
    @(negedge clock);
    data_in = 8'hA5;
    parity_type = 2'b10;
    baud_rate = 2'b11;
    send = 1'b1;
    exp_q.push_back('{bits: 11'b1_0_1010_0101_0, div: 52});
    exp_q.push_back('{bits: 11'b1_0_0011_1100_0, div: 104});
    n = frames_started;
    repeat (10) @(negedge clock);
    data_in = 8'h3C;
    baud_rate = 2'b10;
    exp_done++;
    wait_done(exp_done, 700);
    d1 = done_cyc;
    repeat (3) @(negedge clock);
    send = 1'b0;
    check(frames_started == n + 2, "b2b_second_started",
          frames_started, n + 2);
    check(start_cyc - d1 == 1, "b2b_idle_gap", start_cyc - d1, 1);
    exp_done++;
    wait_done(exp_done, 1300);

    // send pulsed during DATA is ignored
    issue(8'h5A, 2'b01, 2'b11, 11'b1_1_0101_1010_0, 52);
    exp_done++;
    repeat (150) @(negedge clock);
    data_in = 8'hFF;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    wait_done(exp_done, 700);
    repeat (30) @(negedge clock);
    check(done_seen == exp_done, "ignored_send_done_count",
          done_seen, exp_done);

    // reset during data bit 4 (A5 bit4 is 0)
    issue(8'hA5, 2'b10, 2'b11, 11'b1_0_1010_0101_0, 52);
    repeat (5 * 52 + 20) @(negedge clock);
    check(data_tx === 1'b0 && active_flag === 1'b1, "pre_reset_bit4",
          int'({data_tx, active_flag}), 2'b01);
    #3 reset_n = 1'b0;
    #1;
    check(data_tx === 1'b1 && active_flag === 1'b0, "async_reset_mid",
          int'({data_tx, active_flag}), 2'b10);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    check(done_seen == exp_done, "reset_no_done", done_seen, exp_done);
    issue(8'h3C, 2'b10, 2'b11, 11'b1_0_0011_1100_0, 52);
    exp_done++;
    wait_done(exp_done, 700);

    repeat (20) @(negedge clock);
    check(done_seen == exp_done, "total_done", done_seen, exp_done);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
